// File: rtl/mov_pkg.sv
// rtl/mov_pkg.sv - shared encodings and FSM state type for the move register bank
package mov_pkg;

    // op_mode encodings
    localparam logic [1:0] MOV_OP_MOV  = 2'b00;
    localparam logic [1:0] MOV_OP_MOVI = 2'b01;
    localparam logic [1:0] MOV_OP_SWAP = 2'b10;
    localparam logic [1:0] MOV_OP_CLR  = 2'b11;

    // Control FSM: SWAP2 holds the second half-write of a swap
    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } mov_state_t;

    // Only MOV and SWAP read a source register, so only they range-check op_rs
    function automatic logic mov_needs_rs(input logic [1:0] mode);
        return (mode == MOV_OP_MOV) || (mode == MOV_OP_SWAP);
    endfunction

endpackage

// File: rtl/mov_regbank_if.sv
// rtl/mov_regbank_if.sv - operation handshake and read-port bundle for mov_regbank
interface mov_regbank_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_mode;
    logic [AW-1:0]    op_rd;
    logic [AW-1:0]    op_rs;
    logic [WIDTH-1:0] op_imm;
    logic             done;
    logic             err;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    // Decode side issues operations and reads the datapath port
    modport master (
        output op_valid, op_mode, op_rd, op_rs, op_imm, rd_addr,
        input  op_ready, done, err, rd_data
    );

    // Register bank side
    modport slave (
        input  op_valid, op_mode, op_rd, op_rs, op_imm, rd_addr,
        output op_ready, done, err, rd_data
    );
endinterface

// File: rtl/mov_reg_cell.sv
// rtl/mov_reg_cell.sv - single WIDTH-bit register with write enable and async active-low reset
module mov_reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value unless written; reset clears the cell immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mov_regbank.sv
// rtl/mov_regbank.sv - NREGS x WIDTH move-class register bank (MOV/MOVI/SWAP/CLR); optional MOV_FLAGS_EN adds flag_z/flag_n
module mov_regbank
    import mov_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    mov_regbank_if.slave  bus
`ifdef MOV_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_n
`endif
);

    // NREGS widened by one bit so the range compare works when NREGS == 2**AW
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [WIDTH-1:0] q [NREGS];

    // Single internal write port shared by all operations and both swap halves
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    mov_state_t       state;
    logic [WIDTH-1:0] tmp;
    logic [AW-1:0]    swap_rs;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    logic             accept;
    logic             rd_ok;
    logic             rs_ok;
    logic             op_bad;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] dst_data;
    logic [WIDTH-1:0] port_data;

    assign bus.op_ready = ready_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rd_data  = port_data;

    assign accept = bus.op_valid && ready_q && (state == IDLE);
    assign rd_ok  = {1'b0, bus.op_rd} < NREGS_W;
    assign rs_ok  = {1'b0, bus.op_rs} < NREGS_W;
    assign op_bad = !rd_ok || (mov_needs_rs(bus.op_mode) && !rs_ok);

    // Read muxes over committed state: source, destination and datapath port; out of range reads 0
    always_comb begin
        src_data  = '0;
        dst_data  = '0;
        port_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.op_rs == AW'(i)) begin
                src_data = q[i];
            end
            if (bus.op_rd == AW'(i)) begin
                dst_data = q[i];
            end
            if (bus.rd_addr == AW'(i)) begin
                port_data = q[i];
            end
        end
    end

    // Select the write for this edge: swap second half, or an accepted in-range operation
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.op_rd;
        wr_data = '0;
        if (state == SWAP2) begin
            wr_en   = 1'b1;
            wr_addr = swap_rs;
            wr_data = tmp;
        end else if (accept && !op_bad) begin
            wr_en = 1'b1;
            case (bus.op_mode)
                MOV_OP_MOV:  wr_data = src_data;
                MOV_OP_MOVI: wr_data = bus.op_imm;
                MOV_OP_SWAP: wr_data = src_data;
                default:     wr_data = '0;
            endcase
        end
    end

    // Register array: one cell per architectural register
    for (genvar g = 0; g < NREGS; g++) begin : g_cell
        mov_reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .we  (wr_en && (wr_addr == AW'(g))),
            .d   (wr_data),
            .q   (q[g])
        );
    end

    // Control FSM with registered ready/done/err; SWAP parks old R[rd] in tmp for the second half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tmp     <= '0;
            swap_rs <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_bad) begin
                            err_q <= 1'b1;
                        end else if (bus.op_mode == MOV_OP_SWAP) begin
                            tmp     <= dst_data;
                            swap_rs <= bus.op_rs;
                            state   <= SWAP2;
                            ready_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SWAP2: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef MOV_FLAGS_EN
    // Flags track the value of every committed write, including each swap half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (wr_en) begin
            flag_z <= (wr_data == '0);
            flag_n <= wr_data[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_mov_regbank.sv
// tb/tb_mov_regbank.sv - self-checking bench for mov_regbank (NREGS=6) with randomized model comparison
`timescale 1ns/10ps
module tb_mov_regbank;

    localparam int W = 16;
    localparam int N = 6;
    localparam int A = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mov_regbank_if #(.WIDTH(W), .NREGS(N)) bus ();

`ifdef MOV_FLAGS_EN
    logic flag_z;
    logic flag_n;
`endif

    mov_regbank #(.WIDTH(W), .NREGS(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus)
`ifdef MOV_FLAGS_EN
        ,
        .flag_z (flag_z),
        .flag_n (flag_n)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents and expected flags
    logic [W-1:0] m [8];
    logic         ef_z = 1'b0;
    logic         ef_n = 1'b0;

    // Apply one operation to the model; returns 1 if the operation is rejected
    function automatic bit model_op(input logic [1:0] mode, input int rd, input int rs, input logic [W-1:0] imm);
        logic [W-1:0] t;
        logic [W-1:0] last;
        bit bad;
        bad = (rd >= N) || (((mode == 2'd0) || (mode == 2'd2)) && (rs >= N));
        if (bad) return 1'b1;
        case (mode)
            2'd0: begin m[rd] = m[rs]; last = m[rd]; end
            2'd1: begin m[rd] = imm;   last = imm;   end
            2'd2: begin t = m[rd]; m[rd] = m[rs]; m[rs] = t; last = t; end
            default: begin m[rd] = '0; last = '0; end
        endcase
        ef_z = (last == '0);
        ef_n = last[W-1];
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m[i] = '0;
        ef_z = 1'b0;
        ef_n = 1'b0;
    endfunction

    task automatic drive(input logic [1:0] mode, input int rd, input int rs, input logic [W-1:0] imm);
        bus.op_valid = 1'b1;
        bus.op_mode  = mode;
        bus.op_rd    = A'(rd);
        bus.op_rs    = A'(rs);
        bus.op_imm   = imm;
    endtask

    task automatic release_op();
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        rst = 1'b0;
        release_op();
        bus.op_mode = 2'd0; bus.op_rd = '0; bus.op_rs = '0; bus.op_imm = '0; bus.rd_addr = '0;
        model_clear();
        #12;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.op_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = A'(a); #0.1; exp = '0;
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL reset_reg[%0d] got %h exp %h", a, bus.rd_data, exp); end
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_movi();
        @(negedge clk);
        drive(2'd1, 3, 0, 16'h000A);
        void'(model_op(2'd1, 3, 0, 16'h000A));
        @(posedge clk); #1;
        release_op();
        bus.rd_addr = 3'd3; #0.1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL movi_done got %b exp 1", bus.done); end
        checks++; if (bus.rd_data !== 16'h000A) begin errors++; $display("FAIL movi_r3 got %h exp 000a", bus.rd_data); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL movi_done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_swap();
        @(negedge clk);
        drive(2'd1, 1, 0, 16'hF00C); void'(model_op(2'd1, 1, 0, 16'hF00C));
        @(posedge clk); #1;
        drive(2'd1, 2, 0, 16'h1234); void'(model_op(2'd1, 2, 0, 16'h1234));
        @(posedge clk); #1;
        drive(2'd2, 1, 2, '0); void'(model_op(2'd2, 1, 2, '0));
        @(posedge clk); #1;
        release_op();
        checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL swap_ready_low got %b exp 0", bus.op_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL swap_early_done got %b exp 0", bus.done); end
        @(posedge clk); #1;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_back got %b exp 1", bus.op_ready); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL swap_done got %b exp 1", bus.done); end
        bus.rd_addr = 3'd1; #0.1;
        checks++; if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL swap_r1 got %h exp 1234", bus.rd_data); end
        bus.rd_addr = 3'd2; #0.1;
        checks++; if (bus.rd_data !== 16'hF00C) begin errors++; $display("FAIL swap_r2 got %h exp f00c", bus.rd_data); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL swap_single_done got %b exp 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(2'd1, 0, 0, 16'hFFFF); void'(model_op(2'd1, 0, 0, 16'hFFFF));
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", bus.done); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b exp 1", bus.op_ready); end
        drive(2'd0, 5, 0, '0); void'(model_op(2'd0, 5, 0, '0));
        @(posedge clk); #1;
        release_op();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", bus.done); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b exp 1", bus.op_ready); end
        bus.rd_addr = 3'd5; #0.1;
        checks++; if (bus.rd_data !== 16'hFFFF) begin errors++; $display("FAIL b2b_r5 got %h exp ffff", bus.rd_data); end
    endtask

    task automatic test_range();
        logic [W-1:0] exp;
        logic [W-1:0] r2_before;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            case (k)
                0: begin drive(2'd0, 7, 0, '0);      void'(model_op(2'd0, 7, 0, '0)); end
                1: begin drive(2'd1, 6, 0, 16'hBEEF); void'(model_op(2'd1, 6, 0, 16'hBEEF)); end
                default: begin drive(2'd2, 1, 7, '0); void'(model_op(2'd2, 1, 7, '0)); end
            endcase
            @(posedge clk); #1;
            release_op();
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL range_err[%0d] got %b exp 1", k, bus.err); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL range_done[%0d] got %b exp 0", k, bus.done); end
            checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL range_ready[%0d] got %b exp 1", k, bus.op_ready); end
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = A'(a); #0.1; exp = (a < N) ? m[a] : '0;
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL range_reg[%0d] got %h exp %h", a, bus.rd_data, exp); end
        end
        r2_before = m[2];
        @(negedge clk);
        drive(2'd2, 2, 2, '0); void'(model_op(2'd2, 2, 2, '0));
        @(posedge clk); #1;
        release_op();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL swap_same_early got %b exp 0", bus.done); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL swap_same_done got %b exp 1", bus.done); end
        bus.rd_addr = 3'd2; #0.1;
        checks++; if (bus.rd_data !== r2_before) begin errors++; $display("FAIL swap_same_r2 got %h exp %h", bus.rd_data, r2_before); end
    endtask

    task automatic test_reset_mid_swap();
        logic [W-1:0] exp;
        @(negedge clk);
        drive(2'd1, 3, 0, 16'hABCD); void'(model_op(2'd1, 3, 0, 16'hABCD));
        @(posedge clk); #1;
        drive(2'd1, 4, 0, 16'h5555); void'(model_op(2'd1, 4, 0, 16'h5555));
        @(posedge clk); #1;
        drive(2'd2, 3, 4, '0);
        @(posedge clk); #1;
        release_op();
        rst = 1'b0;
        model_clear();
        #1;
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL midswap_ready got %b exp 1", bus.op_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midswap_done got %b exp 0", bus.done); end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = A'(a); #0.1; exp = '0;
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL midswap_reg[%0d] got %h exp %h", a, bus.rd_data, exp); end
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midswap_late_done got %b exp 0", bus.done); end
        checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL midswap_late_ready got %b exp 1", bus.op_ready); end
    endtask

`ifdef MOV_FLAGS_EN
    task automatic test_flags();
        @(negedge clk);
        drive(2'd3, 4, 0, '0); void'(model_op(2'd3, 4, 0, '0));
        @(posedge clk); #1;
        release_op();
        checks++; if (flag_z !== 1'b1 || flag_n !== 1'b0) begin errors++; $display("FAIL flags_clr got z%b n%b exp z1 n0", flag_z, flag_n); end
        @(negedge clk);
        drive(2'd1, 4, 0, 16'h8000); void'(model_op(2'd1, 4, 0, 16'h8000));
        @(posedge clk); #1;
        release_op();
        checks++; if (flag_z !== 1'b0 || flag_n !== 1'b1) begin errors++; $display("FAIL flags_movi got z%b n%b exp z0 n1", flag_z, flag_n); end
        @(negedge clk);
        drive(2'd3, 7, 0, '0); void'(model_op(2'd3, 7, 0, '0));
        @(posedge clk); #1;
        release_op();
        checks++; if (flag_z !== 1'b0 || flag_n !== 1'b1) begin errors++; $display("FAIL flags_reject got z%b n%b exp z0 n1", flag_z, flag_n); end
    endtask
`endif

    task automatic test_random();
        logic [1:0]   mode;
        logic [W-1:0] imm;
        logic [W-1:0] exp;
        int           rd;
        int           rs;
        int           ra;
        bit           bad;
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            rd   = $urandom_range(0, 7);
            rs   = $urandom_range(0, 7);
            imm  = W'($urandom);
            if ($urandom_range(0, 7) == 0) imm = '0;
            drive(mode, rd, rs, imm);
            bad = model_op(mode, rd, rs, imm);
            @(posedge clk); #1;
            release_op();
            if (mode == 2'd2 && !bad) begin
                checks++; if (bus.op_ready !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rnd_swap_half[%0d] got ready%b done%b exp ready0 done0", it, bus.op_ready, bus.done); end
                @(posedge clk); #1;
            end
            checks++; if (bus.done !== !bad || bus.err !== bad) begin errors++; $display("FAIL rnd_status[%0d] mode %0d rd %0d rs %0d got done%b err%b exp done%b err%b", it, mode, rd, rs, bus.done, bus.err, !bad, bad); end
            ra = $urandom_range(0, 7);
            bus.rd_addr = A'(ra); #0.1;
            exp = (ra < N) ? m[ra] : '0;
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL rnd_read[%0d] addr %0d got %h exp %h", it, ra, bus.rd_data, exp); end
`ifdef MOV_FLAGS_EN
            checks++; if (flag_z !== ef_z || flag_n !== ef_n) begin errors++; $display("FAIL rnd_flags[%0d] got z%b n%b exp z%b n%b", it, flag_z, flag_n, ef_z, ef_n); end
`endif
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = A'(a); #0.1; exp = (a < N) ? m[a] : '0;
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL rnd_final[%0d] got %h exp %h", a, bus.rd_data, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_movi();
        test_swap();
        test_back_to_back();
        test_range();
        test_reset_mid_swap();
`ifdef MOV_FLAGS_EN
        test_flags();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
